// File: rtl/tx_seq_pkg.sv
// Shared definitions for the Q-channel transmit rate sequencer: state encoding,
// rate ratios relative to clk, and the phase-counter width.
package tx_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

    localparam int INT_RATIO = 2;
    localparam int SAM_RATIO = 4;
    localparam int SYM_RATIO = 16;
    localparam int PHASE_W   = 4;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYM_RATIO - 1);

    // Ratios are powers of two, so a strobe fires when the low phase bits are zero.
    function automatic logic on_rate(input logic [PHASE_W-1:0] ph, input int ratio);
        return (ph & PHASE_W'(ratio - 1)) == '0;
    endfunction

endpackage

// File: rtl/tx_rate_sequencer_if.sv
// Control/strobe bundle between the sequencer and the transmit chain.
interface tx_rate_sequencer_if;
    import tx_seq_pkg::*;

    logic               start;
    logic               stop;
    logic               int_en;
    logic               sam_en;
    logic               sym_en;
    logic               data_gate;
    logic               clear_accum;
    logic               busy;
    logic [PHASE_W-1:0] phase;

    modport master (
        output start, stop,
        input  int_en, sam_en, sym_en, data_gate, clear_accum, busy, phase
    );

    modport slave (
        input  start, stop,
        output int_en, sam_en, sym_en, data_gate, clear_accum, busy, phase
    );

endinterface

// File: rtl/tx_phase_gen.sv
// Symbol phase counter with registered clock-enable decode; strobes are decoded
// from the phase value being loaded so they line up with the phase output.
module tx_phase_gen
    import tx_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic               i_sync,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_int_en,
    output logic               o_sam_en,
    output logic               o_sym_en
);

    logic [PHASE_W-1:0] r_phase;
    logic               r_int_en;
    logic               r_sam_en;
    logic               r_sym_en;
    logic [PHASE_W-1:0] w_phase_nxt;

    assign w_phase_nxt = i_sync ? '0 : r_phase + PHASE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= '0;
            r_int_en <= 1'b0;
            r_sam_en <= 1'b0;
            r_sym_en <= 1'b0;
        end else if (!i_run) begin
            r_phase  <= '0;
            r_int_en <= 1'b0;
            r_sam_en <= 1'b0;
            r_sym_en <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_int_en <= on_rate(w_phase_nxt, INT_RATIO);
            r_sam_en <= on_rate(w_phase_nxt, SAM_RATIO);
            r_sym_en <= on_rate(w_phase_nxt, SYM_RATIO);
        end
    end

    assign o_phase  = r_phase;
    assign o_int_en = r_int_en;
    assign o_sam_en = r_sam_en;
    assign o_sym_en = r_sym_en;

endmodule

// File: rtl/tx_rate_sequencer.sv
// Start/stop sequencing of the Q-channel transmit chain: RUN/FLUSH/IDLE control,
// symbol-boundary aligned data gating and accumulation-window framing.
//
// state    | meaning
// ST_IDLE  | chain stopped, phase held at 0, all strobes low
// ST_RUN   | strobes running, source data passed (data_gate=1)
// ST_FLUSH | strobes running, zero data driven to drain filter delay lines
module tx_rate_sequencer
    import tx_seq_pkg::*;
#(
    parameter int ACC_SYMS   = 1024,
    parameter int FLUSH_SYMS = 8
) (
    input  logic                clk,
    input  logic                reset,
    tx_rate_sequencer_if.slave  bus
);

    localparam int SCW = $clog2(ACC_SYMS);
    localparam int FCW = $clog2(FLUSH_SYMS + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_SYMS - 1);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic               r_stop_pend;
    logic               w_stop_pend_nxt;
    logic               r_restart_pend;
    logic               w_restart_pend_nxt;
    logic [FCW-1:0]     r_flush_cnt;
    logic [FCW-1:0]     w_flush_cnt_nxt;
    logic [SCW-1:0]     r_sym_cnt;
    logic [SCW-1:0]     w_sym_cnt_nxt;
    logic               r_data_gate;
    logic               r_clear_accum;
    logic               r_busy;
    logic               w_clear_nxt;
    logic               w_wrap;
    logic               w_run;
    logic               w_sync;
    logic [PHASE_W-1:0] w_phase;
    logic               w_int_en;
    logic               w_sam_en;
    logic               w_sym_en;

    assign w_wrap = (w_phase == PHASE_LAST);
    assign w_run  = (w_state_nxt != ST_IDLE);
    assign w_sync = (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_stop_pend    <= 1'b0;
            r_restart_pend <= 1'b0;
            r_flush_cnt    <= '0;
            r_sym_cnt      <= '0;
            r_data_gate    <= 1'b0;
            r_clear_accum  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_stop_pend    <= w_stop_pend_nxt;
            r_restart_pend <= w_restart_pend_nxt;
            r_flush_cnt    <= w_flush_cnt_nxt;
            r_sym_cnt      <= w_sym_cnt_nxt;
            r_data_gate    <= (w_state_nxt == ST_RUN);
            r_clear_accum  <= w_clear_nxt;
            r_busy         <= w_run;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_stop_pend_nxt    = r_stop_pend;
        w_restart_pend_nxt = r_restart_pend;
        w_flush_cnt_nxt    = r_flush_cnt;
        w_sym_cnt_nxt      = r_sym_cnt;
        w_clear_nxt        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_state_nxt   = ST_RUN;
                    w_sym_cnt_nxt = '0;
                    w_clear_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
                // A stop seen on the wrap edge itself still ends this symbol.
                if (w_wrap) begin
                    if (r_stop_pend || bus.stop) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = '0;
                        w_stop_pend_nxt = 1'b0;
                    end else begin
                        w_sym_cnt_nxt = r_sym_cnt + SCW'(1);
                        w_clear_nxt   = (w_sym_cnt_nxt == '0);
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.start) begin
                    w_restart_pend_nxt = 1'b1;
                end
                if (w_wrap) begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        w_restart_pend_nxt = 1'b0;
                        if (r_restart_pend || bus.start) begin
                            w_state_nxt   = ST_RUN;
                            w_sym_cnt_nxt = '0;
                            w_clear_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt + FCW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    tx_phase_gen u_phase_gen (
        .clk      (clk),
        .rst      (reset),
        .i_run    (w_run),
        .i_sync   (w_sync),
        .o_phase  (w_phase),
        .o_int_en (w_int_en),
        .o_sam_en (w_sam_en),
        .o_sym_en (w_sym_en)
    );

    assign bus.phase       = w_phase;
    assign bus.int_en      = w_int_en;
    assign bus.sam_en      = w_sam_en;
    assign bus.sym_en      = w_sym_en;
    assign bus.data_gate   = r_data_gate;
    assign bus.clear_accum = r_clear_accum;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_tx_rate_sequencer.sv
// Bench for tx_rate_sequencer: directed table, multi-cycle corner sequences and
// random start/stop traffic against a cycle-age reference model.
module tb_tx_rate_sequencer;
    import tx_seq_pkg::*;

    localparam int ACC   = 4;
    localparam int FLUSH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_rate_sequencer_if bus ();

    tx_rate_sequencer #(.ACC_SYMS(ACC), .FLUSH_SYMS(FLUSH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 flush; age counts clocks since the
    // current RUN or FLUSH began (always entered on a symbol boundary).
    int m_mode = 0;
    int m_age  = 0;
    bit m_stop_req = 0;
    bit m_restart  = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic [9:0] exp;   // {int, sam, sym, gate, clr, busy, phase[3:0]}
    } vec_t;

    function automatic logic [9:0] model_out();
        int  pos;
        bit  b;
        logic [9:0] r;
        b   = (m_mode != 0);
        pos = b ? (m_age % SYM_RATIO) : 0;
        r[9]   = b && (pos % INT_RATIO == 0);
        r[8]   = b && (pos % SAM_RATIO == 0);
        r[7]   = b && (pos == 0);
        r[6]   = (m_mode == 1);
        r[5]   = (m_mode == 1) && (pos == 0) && (((m_age / SYM_RATIO) % ACC) == 0);
        r[4]   = b;
        r[3:0] = 4'(pos);
        return r;
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.int_en, bus.sam_en, bus.sym_en, bus.data_gate,
                bus.clear_accum, bus.busy, bus.phase};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_stop_req = 0; m_restart = 0;
    endtask

    task automatic model_step(input logic st, input logic sp);
        case (m_mode)
            0: if (st && !sp) begin m_mode = 1; m_age = 0; end
            1: begin
                if (sp) m_stop_req = 1;
                if ((m_age % SYM_RATIO) == SYM_RATIO - 1 && m_stop_req) begin
                    m_mode = 2; m_age = 0; m_stop_req = 0;
                end else m_age++;
            end
            default: begin
                if (st) m_restart = 1;
                if (m_age + 1 == SYM_RATIO * FLUSH) begin
                    m_mode = m_restart ? 1 : 0;
                    m_age = 0; m_restart = 0;
                end else m_age++;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clk_step(input logic st, input logic sp);
        bus.start = st;
        bus.stop  = sp;
        @(posedge clk);
        model_step(st, sp);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_int, cnt_sam, cnt_sym, cnt_clr, sym_idx, n, since;
        logic [15:0] clr_mask;

        tbl[0] = '{1'b1, 1'b1, 10'b000000_0000};
        tbl[1] = '{1'b0, 1'b1, 10'b000000_0000};
        tbl[2] = '{1'b1, 1'b0, 10'b111111_0000};
        tbl[3] = '{1'b0, 1'b0, 10'b000101_0001};
        tbl[4] = '{1'b1, 1'b0, 10'b100101_0010};
        tbl[5] = '{1'b0, 1'b0, 10'b000101_0011};
        tbl[6] = '{1'b0, 1'b0, 10'b110101_0100};
        tbl[7] = '{1'b0, 1'b0, 10'b000101_0101};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 32'(dut_out()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Directed table: IDLE start+stop, stop in IDLE, start, first symbol phases
        for (int i = 0; i < 8; i++) begin
            bus.start = tbl[i].start;
            bus.stop  = tbl[i].stop;
            @(posedge clk);
            model_step(tbl[i].start, tbl[i].stop);
            #1;
            check($sformatf("table[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Asynchronous reset mid-RUN at phase 7
        clk_step(0, 0);
        clk_step(0, 0);
        check("phase_before_reset", 32'(bus.phase), 32'd7);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 32'(dut_out()), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) clk_step(0, 0);
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        // Start; 64-clock strobe counts, then 12 symbols of clear_accum framing
        cnt_int = 0; cnt_sam = 0; cnt_sym = 0; cnt_clr = 0; clr_mask = '0;
        for (int c = 0; c < 12 * SYM_RATIO; c++) begin
            clk_step(c == 0, 0);
            if (c == 0) check("first_sym_en", 32'(bus.sym_en), 32'd1);
            sym_idx = c / SYM_RATIO;
            cnt_int += int'(bus.int_en);
            cnt_sam += int'(bus.sam_en);
            cnt_sym += int'(bus.sym_en);
            if (bus.clear_accum) begin
                cnt_clr++;
                clr_mask[sym_idx] = 1'b1;
                check("clr_with_sym", 32'(bus.sym_en), 32'd1);
            end
            if (c == 63) begin
                check("int_count_64", cnt_int, 32);
                check("sam_count_64", cnt_sam, 16);
                check("sym_count_64", cnt_sym, 4);
            end
        end
        check("clr_count", cnt_clr, 3);
        check("clr_symbols", 32'(clr_mask), 32'h0111);

        // Stop sampled at phase 5
        for (int i = 0; i < 6; i++) clk_step(0, 0);
        check("phase_at_stop", 32'(bus.phase), 32'd5);
        clk_step(0, 1);
        n = 1;
        while (bus.data_gate && n < 100) begin clk_step(0, 0); n++; end
        check("run_after_stop", n, 11);
        n = 0;
        while (bus.busy && n < 400) begin clk_step(0, 0); n++; end
        check("flush_len", n, 16 * FLUSH);

        // Start during FLUSH -> seamless return to RUN
        clk_step(1, 0);
        clk_step(0, 1);
        n = 0;
        while (bus.data_gate && n < 100) begin clk_step(0, 0); n++; end
        since = 0;
        for (int i = 0; i < 20; i++) begin clk_step(0, 0); since++; if (bus.sym_en) since = 0; end
        clk_step(1, 0); since++; if (bus.sym_en) since = 0;
        n = 0;
        while (!bus.data_gate && n < 400) begin
            clk_step(0, 0); n++; since++;
            if (bus.sym_en) begin
                if (!bus.data_gate) check("flush_sym_gap", since, SYM_RATIO);
                since = 0;
            end
        end
        check("restart_gap", since, 0);
        check("restart_sym_clr", 32'({bus.sym_en, bus.clear_accum, bus.busy}), 32'b111);

        // start+stop together in RUN at phase 0 -> FLUSH at the next wrap
        clk_step(1, 1);
        n = 1;
        while (bus.data_gate && n < 100) begin clk_step(0, 0); n++; end
        check("start_stop_run", n, SYM_RATIO);
        n = 0;
        while (bus.busy && n < 400) begin clk_step(0, 0); n++; end
        check("flush_len_2", n, 16 * FLUSH);

        // Random start/stop traffic against the model
        for (int c = 0; c < 4000; c++) begin
            clk_step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
